data_channel_scheduler: RTL and testbench
=========================================

// Module: data_channel_scheduler
// PURPOSE
//  Shares one ECC Data_Channel instance between NUM_REQ requesters using round-robin arbitration.
//  Each accepted word is driven into the channel, and the corrected output is captured after CH_LATENCY cycles.
//  Uncorrectable errors are retried up to MAX_RETRY times, then one tagged response is returned to the requester.
//  Saturating error statistics are kept for software.
// PARAMETERS
//  NUM_REQ    4   requester count, 2..8; ID_W = $clog2(NUM_REQ)
//  DATA_W     8   data word width, equal to the Data_Channel data_in/data_out width
//  CH_LATENCY 2   rising edges from ch_data_in stable until ch_data_out and flags are valid; >=1
//  MAX_RETRY  2   extra channel attempts after an uncorrectable result; 0..7
//  CNT_W      16  statistics counter width
// PORTS
//  clk             in   1               single clock, rising edge
//  rst             in   1               asynchronous, active-low reset
//  req_valid       in   NUM_REQ         per-requester word-pending flag
//  req_data        in   NUM_REQ*DATA_W  requester i word is bits [i*DATA_W +: DATA_W]
//  req_ready       out  NUM_REQ         grant/accept; at most one bit high
//  ch_data_in      out  DATA_W          drives Data_Channel data_in
//  ch_data_out     in   DATA_W          from Data_Channel data_out
//  ch_err_det      in   1               from Data_Channel error_detected
//  ch_err_corr     in   1               from Data_Channel error_corrected
//  rsp_valid       out  1               response available
//  rsp_ready       in   1               response consumer ready
//  rsp_id          out  ID_W            requester index of the response
//  rsp_data        out  DATA_W          channel output word
//  rsp_status      out  2               00 clean, 01 corrected, 10 uncorrectable, 11 unused
//  busy            out  1               high whenever state is not IDLE
//  cnt_clr         in   1               synchronous clear of both counters
//  cnt_corrected   out  CNT_W           responses with status 01
//  cnt_uncorr      out  CNT_W           responses with status 10
// BEHAVIOUR
//  Reset (rst=0, asynchronous)
//   - Every output goes to 0, state goes to IDLE, retry count to 0, rr pointer to NUM_REQ-1.
//   - An in-flight transaction is discarded and no response is produced for it.
//  FSM states: IDLE, WAIT, CHECK, RESP.
//  IDLE
//   - req_ready is combinational: the one-hot bit of the first requester with req_valid=1,
//     searching from rr+1 upward and wrapping modulo NUM_REQ.
//   - The transfer completes on the edge where req_valid&req_ready; on that edge:
//     - latch the word and the id;
//     - rr <= id;
//     - retry <= 0;
//     - lat_cnt <= CH_LATENCY-1;
//     - go to WAIT.
//   - req_ready is 0 in every state other than IDLE.
//  ch_data_in: registered; loaded with the latched word on accept and held until the next accept.
//  WAIT
//   - Decrement lat_cnt each cycle.
//   - When lat_cnt==0, go to CHECK. The channel outputs are sampled on the CH_LATENCY-th edge after accept.
//  CHECK, classified by the sampled flags:
//   - err_det=0: status 00.
//   - err_det=1 and err_corr=1: status 01.
//   - err_det=1 and err_corr=0 with retry<MAX_RETRY: retry++, reload lat_cnt, return to WAIT.
//     ch_data_in is unchanged, so the same word is re-driven. No response is produced.
//   - err_det=1 and err_corr=0 with retry==MAX_RETRY: status 10.
//   - For every outcome except a retry, register rsp_data, rsp_id and rsp_status, then go to RESP.
//  RESP
//   - rsp_valid=1; rsp_* are held stable until the edge with rsp_ready=1, then go to IDLE.
//   - Requests arbitrate again in the cycle after RESP.
//  Latency: a clean response has rsp_valid high CH_LATENCY+1 cycles after the accept edge.
//   Each retry adds CH_LATENCY+1 cycles.
//  Counters
//   - Increment when the RESP state is entered, by final status only.
//   - Saturate at all-ones.
//   - cnt_clr has priority over a same-cycle increment; the result is 0.
//  Throughput: at most one word in flight, so a requester holding req_valid never starves.
//   It waits at most NUM_REQ-1 transactions.
//  req_valid dropping in IDLE before a grant is legal and has no effect.
// TESTING (NUM_REQ=4, CH_LATENCY=2, MAX_RETRY=2; channel model with injectable flags)
//  1. Pulse rst=0 mid-run -> every output is 0 and busy=0.
//     After release, with only req_valid[0]=1, requester 0 is the first grant.
//  2. req_valid=0001 and req0=8'hAA with a clean channel -> req_ready=0001 for 1 cycle.
//     rsp_valid goes high 3 cycles after accept with rsp_id=0, rsp_data=8'hAA and rsp_status=00.
//  3. req_valid=1111 held, with rsp_ready=1 -> grants follow 0,1,2,3,0,1 and req_ready is never multi-hot.
//  4. Force err_det=1 and err_corr=1 on the word 8'hCC -> status 01 and cnt_corrected=1.
//     Then cnt_clr plus a second 01 response in the same cycle -> cnt_corrected=0.
//  5. Persistent err_det=1 with err_corr=0 -> three channel attempts, then status 10 at 9 cycles after accept,
//     and cnt_uncorr=1. With the error on the first attempt only -> status 00 at 6 cycles.
//  6. rsp_ready=0 for 5 cycles with other requests pending -> rsp_* stay stable and there is no grant.
//     Separately, rst=0 during WAIT -> no response and the block returns to IDLE.

Source files
------------

// File: rtl/data_channel_scheduler.sv
// Round-robin scheduler sharing one ECC data channel among NUM_REQ requesters,
// with bounded retry of uncorrectable results and saturating error statistics.
//
// state | meaning
// IDLE  | arbitrate, accept one requester word
// WAIT  | count down channel latency, sample channel outputs at terminal count
// CHECK | classify sampled flags: respond or re-drive the same word
// RESP  | hold response until rsp_ready
module data_channel_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int CH_LATENCY = 2,
  parameter int MAX_RETRY  = 2,
  parameter int CNT_W      = 16,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         ch_data_in,
  input  logic [DATA_W-1:0]         ch_data_out,
  input  logic                      ch_err_det,
  input  logic                      ch_err_corr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [1:0]                rsp_status,
  output logic                      busy,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          cnt_corrected,
  output logic [CNT_W-1:0]          cnt_uncorr
);

  localparam int LAT_W = (CH_LATENCY > 1) ? $clog2(CH_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(CH_LATENCY - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, RESP} state_t;

  state_t              state_q;
  logic [ID_W-1:0]     rr_q;
  logic [LAT_W-1:0]    lat_q;
  logic [2:0]          retry_q;
  logic [DATA_W-1:0]   ch_in_q;
  logic [DATA_W-1:0]   samp_data_q;
  logic                samp_det_q;
  logic                samp_corr_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [1:0]          rsp_status_q;
  logic [CNT_W-1:0]    cnt_corr_q;
  logic [CNT_W-1:0]    cnt_unc_q;

  logic                found;
  logic [ID_W-1:0]     idx;
  logic [ID_W-1:0]     gnt_id;
  logic [DATA_W-1:0]   gnt_word;
  logic [NUM_REQ-1:0]  gnt_oh;

  // first valid requester after the last grant, wrapping
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    gnt_id   = '0;
    gnt_word = '0;
    gnt_oh   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt_id) gnt_word = req_data[i*DATA_W +: DATA_W];
    end
    if (found && state_q == IDLE) gnt_oh[gnt_id] = 1'b1;
  end

  assign req_ready     = gnt_oh;
  assign busy          = (state_q != IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign ch_data_in    = ch_in_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_status    = rsp_status_q;
  assign cnt_corrected = cnt_corr_q;
  assign cnt_uncorr    = cnt_unc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_q         <= ID_W'(NUM_REQ - 1);
      lat_q        <= '0;
      retry_q      <= '0;
      ch_in_q      <= '0;
      samp_data_q  <= '0;
      samp_det_q   <= 1'b0;
      samp_corr_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= 2'b00;
      cnt_corr_q   <= '0;
      cnt_unc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            ch_in_q <= gnt_word;
            rr_q    <= gnt_id;
            retry_q <= '0;
            lat_q   <= LAT_RELOAD;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (lat_q == '0) begin
            samp_data_q <= ch_data_out;
            samp_det_q  <= ch_err_det;
            samp_corr_q <= ch_err_corr;
            state_q     <= CHECK;
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        CHECK: begin
          if (samp_det_q && !samp_corr_q && (retry_q < RETRY_MAX)) begin
            // ch_in_q is untouched, so the same word is re-driven
            retry_q <= retry_q + 3'd1;
            lat_q   <= LAT_RELOAD;
            state_q <= WAIT;
          end else begin
            rsp_data_q <= samp_data_q;
            rsp_id_q   <= rr_q;
            state_q    <= RESP;
            if (!samp_det_q) begin
              rsp_status_q <= 2'b00;
            end else if (samp_corr_q) begin
              rsp_status_q <= 2'b01;
              if (cnt_corr_q != '1) cnt_corr_q <= cnt_corr_q + CNT_W'(1);
            end else begin
              rsp_status_q <= 2'b10;
              if (cnt_unc_q != '1) cnt_unc_q <= cnt_unc_q + CNT_W'(1);
            end
          end
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // clear overrides any increment on the same edge
      if (cnt_clr) begin
        cnt_corr_q <= '0;
        cnt_unc_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_channel_scheduler.sv
// Bench for data_channel_scheduler: directed and random transactions against
// a transaction-level model of arbitration order, latency, status and counters.
module tb_data_channel_scheduler;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 2;
  localparam int MAXR    = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  ch_data_in;
  logic [7:0]  ch_data_out;
  logic        ch_err_det;
  logic        ch_err_corr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;
  logic        cnt_clr;
  logic [15:0] cnt_corrected;
  logic [15:0] cnt_uncorr;
  logic [7:0]  flip_mask;

  int tests;
  int fails;
  int exp_rr;
  int exp_corr;
  int exp_unc;

  data_channel_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(8), .CH_LATENCY(LAT), .MAX_RETRY(MAXR), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ch_data_in(ch_data_in), .ch_data_out(ch_data_out),
    .ch_err_det(ch_err_det), .ch_err_corr(ch_err_corr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_status(rsp_status), .busy(busy),
    .cnt_clr(cnt_clr), .cnt_corrected(cnt_corrected), .cnt_uncorr(cnt_uncorr)
  );

  // channel model: combinational pass-through with injectable corruption and flags
  assign ch_data_out = ch_data_in ^ flip_mask;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int model_grant(input logic [3:0] v, input int rr);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = (rr + k) % NUM_REQ;
      if (v[2'(j)]) return j;
    end
    return -1;
  endfunction

  // mode: 0 clean, 1 corrected, 2 persistent uncorrectable, 3 uncorrectable on first attempt only
  task automatic txn(input logic [3:0] vmask, input logic [31:0] data, input int mode,
                     input int hold, input bit clr_at_entry);
    int         g;
    int         cyc;
    int         attempts;
    logic [7:0] word;
    logic [7:0] mask;
    logic [7:0] exp_data;
    logic [1:0] exp_status;
    logic [1:0] gi;
    req_data  = data;
    req_valid = vmask;
    g         = model_grant(vmask, exp_rr);
    gi        = 2'(g);
    word      = 8'(data >> (8 * g));
    mask      = 8'($urandom_range(1, 255));
    attempts  = 1;
    exp_status = 2'b00;
    exp_data   = word;
    case (mode)
      1: begin ch_err_det = 1'b1; ch_err_corr = 1'b1; exp_status = 2'b01; end
      2: begin
        ch_err_det = 1'b1; ch_err_corr = 1'b0; flip_mask = mask;
        attempts = MAXR + 1; exp_status = 2'b10; exp_data = word ^ mask;
      end
      3: begin ch_err_det = 1'b1; ch_err_corr = 1'b0; flip_mask = mask; attempts = 2; end
      default: ;
    endcase
    #1;
    check("grant_onehot", 32'(req_ready), 32'(4'b0001 << gi));
    tick();
    exp_rr = g;
    check("ready_after_accept", 32'(req_ready), 32'd0);
    check("ch_data_in", 32'(ch_data_in), 32'(word));
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      if (mode == 3 && cyc == LAT) begin
        ch_err_det = 1'b0; ch_err_corr = 1'b0; flip_mask = 8'h00;
      end
      if (clr_at_entry && cyc == attempts * (LAT + 1) - 1) cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      cyc++;
      check("busy_in_flight", 32'(busy), 32'd1);
      check("no_grant_in_flight", 32'(req_ready), 32'd0);
    end
    check("latency", 32'(cyc), 32'(attempts * (LAT + 1)));
    if (clr_at_entry) begin
      exp_corr = 0; exp_unc = 0;
    end else if (exp_status == 2'b01) exp_corr++;
    else if (exp_status == 2'b10) exp_unc++;
    check("rsp_id", 32'(rsp_id), 32'(gi));
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("rsp_status", 32'(rsp_status), 32'(exp_status));
    check("cnt_corrected", 32'(cnt_corrected), 32'(exp_corr));
    check("cnt_uncorr", 32'(cnt_uncorr), 32'(exp_unc));
    ch_err_det = 1'b0; ch_err_corr = 1'b0; flip_mask = 8'h00;
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_id", 32'(rsp_id), 32'(gi));
      check("hold_data", 32'(rsp_data), 32'(exp_data));
      check("hold_status", 32'(rsp_status), 32'(exp_status));
      check("hold_no_grant", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0000;
    check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
    check("idle_after_rsp", 32'(busy), 32'd0);
  endtask

  task automatic reset_in_wait();
    req_data  = $urandom;
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = 4'b0000;
    tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_ch_data_in", 32'(ch_data_in), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt_corrected", 32'(cnt_corrected), 32'd0);
    check("rst_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    exp_rr = NUM_REQ - 1; exp_corr = 0; exp_unc = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
      check("idle_after_reset", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] vm;
    int         md;
    int         hd;
    bit         cl;
    tests = 0; fails = 0;
    rst = 1'b0; req_valid = 4'b0000; req_data = 32'h0;
    ch_err_det = 1'b0; ch_err_corr = 1'b0; flip_mask = 8'h00;
    rsp_ready = 1'b0; cnt_clr = 1'b0;
    exp_rr = NUM_REQ - 1; exp_corr = 0; exp_unc = 0;
    tick();
    tick();
    check("init_busy", 32'(busy), 32'd0);
    check("init_rsp_valid", 32'(rsp_valid), 32'd0);
    check("init_ch_data_in", 32'(ch_data_in), 32'd0);
    rst = 1'b1;
    tick();

    // single clean word from requester 0
    txn(4'b0001, 32'h0000_00AA, 0, 0, 1'b0);

    // fresh reset, then all requesters pending: grants rotate 0,1,2,3,0,1
    reset_in_wait();
    for (int n = 0; n < 6; n++) txn(4'b1111, $urandom, 0, 0, 1'b0);

    // corrected word, then a corrected word landing on a counter clear
    txn(4'b0100, 32'h00CC_0000, 1, 0, 1'b0);
    txn(4'b0100, 32'h00CC_0000, 1, 0, 1'b1);

    // persistent and first-attempt-only uncorrectable errors
    txn(4'b0001, $urandom, 2, 0, 1'b0);
    txn(4'b0001, $urandom, 3, 0, 1'b0);

    // response back-pressure with other requests pending
    txn(4'b0011, $urandom, 0, 5, 1'b0);

    // a request withdrawn before any edge has no effect
    req_valid = 4'b0100;
    #1;
    check("withdraw_ready", 32'(req_ready), 32'(4'b0100));
    req_valid = 4'b0000;
    tick();
    check("withdraw_no_accept", 32'(busy), 32'd0);

    // reset mid-transaction, then requester 0 alone gets the first grant
    reset_in_wait();
    txn(4'b0001, $urandom, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      vm = 4'($urandom_range(1, 15));
      md = int'($urandom_range(0, 3));
      hd = int'($urandom_range(0, 3));
      cl = ($urandom_range(0, 7) == 0);
      txn(vm, $urandom, md, hd, cl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
